// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and
// registers the fetched word with its PC into the IF/ID outputs.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | just out of reset, ROM disabled, PC parked at RESET_PC
// RUN   | normal fetch: sequential advance, branch or flush redirect
// PEND  | branch arrived while PC stalled; target held in pend_target
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  stall_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o,
    output logic        id_adel_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pend_target, pend_nxt;
    logic        ce, ce_nxt;
    logic [31:0] pc_inc;
    logic        misaligned;

    assign pc_inc     = pc + 32'd4;
    assign misaligned = (pc[1:0] != 2'b00);
    assign rom_ce_o   = ce;
    assign rom_addr_o = pc;

    // State, PC, pending target and chip-enable registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            pend_target <= 32'd0;
            ce          <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend_target <= pend_nxt;
            ce          <= ce_nxt;
        end
    end

    // Next-state and PC selection; flush always outranks any branch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        pend_nxt  = pend_target;
        ce_nxt    = ce;
        unique case (state)
            IDLE: begin
                // PC stays at RESET_PC so the first real fetch is RESET_PC.
                state_nxt = RUN;
                ce_nxt    = 1'b1;
            end
            RUN: begin
                if (flush_i) begin
                    pc_nxt = new_pc_i;
                end else if (branch_flag_i && !stall_i[0]) begin
                    pc_nxt = branch_target_i;
                end else if (branch_flag_i && stall_i[0]) begin
                    pend_nxt  = branch_target_i;
                    state_nxt = PEND;
                end else if (!stall_i[0]) begin
                    pc_nxt = pc_inc;
                end
            end
            PEND: begin
                // A new branch cannot resolve while the previous one waits.
                if (flush_i) begin
                    pc_nxt    = new_pc_i;
                    state_nxt = RUN;
                end else if (!stall_i[0]) begin
                    pc_nxt    = pend_target;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
                ce_nxt    = 1'b0;
                pc_nxt    = RESET_PC;
            end
        endcase
    end

    // IF/ID pipeline register: flush, bubble, capture or hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc_o    <= 32'd0;
            id_inst_o  <= 32'd0;
            id_valid_o <= 1'b0;
            id_adel_o  <= 1'b0;
        end else if (flush_i || (stall_i[1] && !stall_i[2])) begin
            id_pc_o    <= 32'd0;
            id_inst_o  <= 32'd0;
            id_valid_o <= 1'b0;
            id_adel_o  <= 1'b0;
        end else if (!stall_i[1]) begin
            id_pc_o    <= pc;
            // A misaligned fetch becomes a NOP; decode raises AdEL from the flag.
            id_inst_o  <= (ce && !misaligned) ? rom_inst_i : 32'd0;
            id_valid_o <= ce;
            id_adel_o  <= ce && misaligned;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch; the ROM model returns the inverted address.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [2:0]  stall_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        id_adel_o;

    int n_vec = 0;
    int n_bad = 0;

    if_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_inst_i      (rom_inst_i),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_valid_o      (id_valid_o),
        .id_adel_o       (id_adel_o)
    );

    assign rom_inst_i = ~rom_addr_o;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] addr);
        chk({tag, " ce"}, {31'd0, rom_ce_o}, 32'd1);
        chk({tag, " addr"}, rom_addr_o, addr);
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic valid, input logic adel);
        chk({tag, " id_pc"}, id_pc_o, pc);
        chk({tag, " id_inst"}, id_inst_o, inst);
        chk({tag, " id_valid"}, {31'd0, id_valid_o}, {31'd0, valid});
        chk({tag, " id_adel"}, {31'd0, id_adel_o}, {31'd0, adel});
    endtask

    initial begin
        rst = 1'b0;
        stall_i = 3'b000;
        flush_i = 1'b0;
        new_pc_i = 32'd0;
        branch_flag_i = 1'b0;
        branch_target_i = 32'd0;

        #3;
        chk("rst ce", {31'd0, rom_ce_o}, 32'd0);
        chk("rst addr", rom_addr_o, 32'd0);
        chk_id("rst", 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        chk("idle ce", {31'd0, rom_ce_o}, 32'd0);

        // Sequential fetch after reset release
        step();
        chk_fetch("f0", 32'h0);
        chk("f0 id_valid", {31'd0, id_valid_o}, 32'd0);
        step();
        chk_fetch("f1", 32'h4);
        chk_id("f1", 32'h0, ~32'h0, 1'b1, 1'b0);
        step();
        chk_fetch("f2", 32'h8);
        chk_id("f2", 32'h4, ~32'h4, 1'b1, 1'b0);
        step();
        chk_fetch("f3", 32'hC);
        chk_id("f3", 32'h8, ~32'h8, 1'b1, 1'b0);

        // Branch with delay slot
        branch_flag_i = 1'b1; branch_target_i = 32'h100;
        step();
        branch_flag_i = 1'b0;
        chk_fetch("br", 32'h100);
        chk_id("br slot", 32'hC, ~32'hC, 1'b1, 1'b0);
        step();
        chk_fetch("br+1", 32'h104);
        chk_id("br tgt", 32'h100, ~32'h100, 1'b1, 1'b0);

        // Branch while PC stalled -> PEND
        stall_i = 3'b111; branch_flag_i = 1'b1; branch_target_i = 32'h200;
        step();
        branch_flag_i = 1'b0;
        chk_fetch("pend0", 32'h104);
        chk_id("pend0", 32'h100, ~32'h100, 1'b1, 1'b0);
        step();
        chk_fetch("pend1", 32'h104);
        stall_i = 3'b000;
        step();
        chk_fetch("pend rel", 32'h200);
        chk_id("pend rel", 32'h104, ~32'h104, 1'b1, 1'b0);
        step();
        chk_fetch("pend+1", 32'h204);
        chk_id("pend+1", 32'h200, ~32'h200, 1'b1, 1'b0);

        // Bubble insertion
        stall_i = 3'b011;
        step();
        stall_i = 3'b000;
        chk_fetch("bub", 32'h204);
        chk_id("bub", 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        chk_fetch("bub+1", 32'h208);
        chk_id("bub+1", 32'h204, ~32'h204, 1'b1, 1'b0);

        // Flush while pending discards the pending target
        stall_i = 3'b111; branch_flag_i = 1'b1; branch_target_i = 32'h300;
        step();
        branch_flag_i = 1'b0;
        chk_fetch("pf0", 32'h208);
        flush_i = 1'b1; new_pc_i = 32'h20;
        step();
        flush_i = 1'b0; stall_i = 3'b000;
        chk_fetch("pflush", 32'h20);
        chk_id("pflush", 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        chk_fetch("pflush+1", 32'h24);
        chk_id("pflush+1", 32'h20, ~32'h20, 1'b1, 1'b0);

        // Flush and branch together: flush wins
        flush_i = 1'b1; new_pc_i = 32'h40; branch_flag_i = 1'b1; branch_target_i = 32'h500;
        step();
        flush_i = 1'b0; branch_flag_i = 1'b0;
        chk_fetch("fb", 32'h40);
        chk_id("fb", 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        chk_fetch("fb+1", 32'h44);

        // Misaligned branch target
        branch_flag_i = 1'b1; branch_target_i = 32'h102;
        step();
        branch_flag_i = 1'b0;
        chk_fetch("mis", 32'h102);
        chk_id("mis slot", 32'h44, ~32'h44, 1'b1, 1'b0);
        step();
        chk_fetch("mis+1", 32'h106);
        chk_id("mis", 32'h102, 32'h0, 1'b1, 1'b1);

        // PC wraps modulo 2^32
        flush_i = 1'b1; new_pc_i = 32'hFFFF_FFFC;
        step();
        flush_i = 1'b0;
        chk_fetch("wrap0", 32'hFFFF_FFFC);
        step();
        chk_fetch("wrap1", 32'h0);
        chk_id("wrap1", 32'hFFFF_FFFC, ~32'hFFFF_FFFC, 1'b1, 1'b0);

        // Async reset mid-PEND loses pending target
        stall_i = 3'b111; branch_flag_i = 1'b1; branch_target_i = 32'h600;
        step();
        branch_flag_i = 1'b0;
        chk_fetch("rp0", 32'h0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst ce", {31'd0, rom_ce_o}, 32'd0);
        chk("arst addr", rom_addr_o, 32'd0);
        chk_id("arst", 32'd0, 32'd0, 1'b0, 1'b0);
        stall_i = 3'b000;
        rst = 1'b1;
        step();
        chk_fetch("rr0", 32'h0);
        step();
        chk_fetch("rr1", 32'h4);
        chk_id("rr1", 32'h0, ~32'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the pipelined MIPS core: owns the program counter, drives chip-enable and address into the combinational instruction ROM, and registers the returned word with its PC into the IF/ID pipeline outputs consumed by decode. Handles sequential PC+4 advance, branch redirects from ID, branches that arrive while the PC is stalled, exception flushes, and misaligned-fetch detection.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_i  in  3  bit0 hold PC, bit1 hold IF stage, bit2 hold ID stage.
- flush_i  in  1  exception flush; redirect to new_pc_i.
- new_pc_i  in  32  flush target.
- branch_flag_i  in  1  taken branch or jump resolved in ID.
- branch_target_i  in  32  branch/jump target.
- rom_ce_o  out  1  ROM chip enable, registered.
- rom_addr_o  out  32  fetch address; equals the PC register.
- rom_inst_i  in  32  ROM read data, combinational from rom_addr_o.
- id_pc_o  out  32  PC of the instruction in IF/ID.
- id_inst_o  out  32  instruction in IF/ID.
- id_valid_o  out  1  IF/ID holds a real instruction.
- id_adel_o  out  1  fetch address error (PC[1:0] != 0).

## Operation
- States: IDLE (after reset, ce=0), RUN, PEND (branch target latched while PC stalled). 32-bit pend_target register.
- IDLE: first rising edge with rst high -> RUN, rom_ce_o<=1; PC stays RESET_PC, so the first fetch is RESET_PC.
- PC update in RUN, priority high to low:
  - flush_i: PC<=new_pc_i.
  - branch_flag_i and !stall_i[0]: PC<=branch_target_i.
  - branch_flag_i and stall_i[0]: pend_target<=branch_target_i, PC held, ->PEND.
  - stall_i[0]: PC held.
  - else PC<=PC+4, modulo 2^32 (32'hFFFF_FFFC -> 0).
- PEND: flush_i -> PC<=new_pc_i, pending discarded, ->RUN; else if !stall_i[0] -> PC<=pend_target, ->RUN; else hold. branch_flag_i ignored in PEND.
- IF/ID register, priority high to low:
  - flush_i: clear (pc 0, inst 0, valid 0, adel 0).
  - stall_i[1] and !stall_i[2]: insert bubble (same zero values).
  - !stall_i[1]: capture; see the capture rule below.
  - else hold.
- Capture rule:
  - id_pc_o<=PC; id_valid_o<=rom_ce_o; id_adel_o<=rom_ce_o & (PC[1:0]!=0).
  - id_inst_o<=rom_inst_i when rom_ce_o and PC aligned, else 0.
- Misaligned PC: fetch still presented; instruction replaced by NOP (0), adel flagged for exception logic downstream.
- rom_ce_o stays 1 after leaving IDLE until reset.
- Branch delay slot: the instruction fetched in the cycle branch_flag_i is high is captured normally and is never squashed by a branch.

## Timing
- Async reset, immediate and without a clock edge:
  - state IDLE, PC=RESET_PC, rom_ce_o=0, pend_target=0.
  - id_pc_o=0, id_inst_o=0, id_valid_o=0, id_adel_o=0.
- Fetch latency: a word addressed in cycle N appears on id_* after edge N+1.
- Branch latency: branch_flag_i sampled at edge N -> rom_addr_o=target in cycle N+1; target instruction on id_* after edge N+2.
- Flush latency: new_pc_i on rom_addr_o the cycle after flush_i; id_* cleared at that same edge.
- Reset asserted mid-PEND: pending target lost, state IDLE.
- flush_i and branch_flag_i in the same cycle: flush wins, branch dropped.

## Test plan
- Release reset, RESET_PC=0, no stalls -> rom_ce_o 0 for one cycle, then rom_addr_o 0,4,8,C; id_pc_o follows one cycle later with id_valid_o=1.
- branch_flag_i=1, target 0x100, for one cycle while rom_addr_o=0xC -> rom_addr_o 0x100 next; id_pc_o sequence 0x8, 0xC (delay slot), 0x100.
- stall_i=3'b111 for 2 cycles, branch_flag_i=1 (target 0x200) in the first -> PC held, PEND; stall release -> rom_addr_o=0x200.
- stall_i=3'b011 for one cycle -> id_valid_o=0, id_inst_o=0, PC unchanged; next cycle resumes at the held PC.
- flush_i=1, new_pc_i=0x20, while in PEND -> rom_addr_o=0x20, pending discarded, id_* cleared.
- branch target 0x102 -> id_adel_o=1, id_inst_o=0, id_valid_o=1; async reset pulse mid-run -> all outputs 0 immediately, rom_addr_o=RESET_PC.
